// File: rtl/cl_rodada_param.sv
// -----------------------------------------------------------------------------
// cl_rodada_param -- turn-based "hit the target" game controller.
//
// Each move a pseudo-random board position (row, column) is generated from a
// free-running 16-bit LFSR. The player whose turn it is has T_LIMITE cycles to
// present a move. A move equal to the target scores one point (saturating).
// Players rotate; after N_RODADAS complete rounds the game ends in FIM.
//
// Ports:
//   clock         single clock, rising edge
//   reset         synchronous reset, active low
//   iniciar       start a game (from INICIAL or FIM)
//   terminar      abort the running game (forces FIM)
//   jogadaLinha   played row
//   jogadaColuna  played column
//   temJogada     move-valid strobe, only honoured while waiting for a move
//   linhaGerada   current target row (registered)
//   colunaGerada  current target column (registered)
//   salvaNova     one-cycle pulse: a new target has just been loaded
//   jogadorAtual  index of the player to move
//   pontos        packed scores, player k at [k*BITS_PONTOS +: BITS_PONTOS]
//   rodada        number of completed rounds
//   acertou       one-cycle pulse: the evaluated move hit the target
//   timeout       one-cycle pulse: the move window expired
//   fim           high while the game is over
//   db_estado     current state code
// -----------------------------------------------------------------------------
module cl_rodada_param #(
    parameter int N_JOGADORES = 2,
    parameter int BITS_POS    = 3,
    parameter int N_RODADAS   = 8,
    parameter int T_LIMITE    = 50000000,
    parameter int BITS_PONTOS = 8,
    localparam int W_JOG      = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1,
    localparam int W_ROD      = $clog2(N_RODADAS + 1)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               iniciar,
    input  logic                               terminar,
    input  logic [BITS_POS-1:0]                jogadaLinha,
    input  logic [BITS_POS-1:0]                jogadaColuna,
    input  logic                               temJogada,
    output logic [BITS_POS-1:0]                linhaGerada,
    output logic [BITS_POS-1:0]                colunaGerada,
    output logic                               salvaNova,
    output logic [W_JOG-1:0]                   jogadorAtual,
    output logic [N_JOGADORES*BITS_PONTOS-1:0] pontos,
    output logic [W_ROD-1:0]                   rodada,
    output logic                               acertou,
    output logic                               timeout,
    output logic                               fim,
    output logic [3:0]                         db_estado
);

    localparam int W_TMR = (T_LIMITE > 1) ? $clog2(T_LIMITE) : 1;

    localparam logic [W_TMR-1:0]       TMR_CARGA  = W_TMR'(T_LIMITE - 1);
    localparam logic [W_JOG-1:0]       ULTIMO_JOG = W_JOG'(N_JOGADORES - 1);
    localparam logic [W_ROD-1:0]       ROD_FINAL  = W_ROD'(N_RODADAS);
    localparam logic [BITS_PONTOS-1:0] PONTOS_MAX = '1;
    localparam logic [15:0]            SEMENTE    = 16'hACE1;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        PREPARA = 3'd1,
        GERA    = 3'd2,
        ESPERA  = 3'd3,
        AVALIA  = 3'd4,
        PROXIMO = 3'd5,
        FIM     = 3'd6
    } estado_t;

    estado_t                          r_estado;
    estado_t                          w_prox;

    logic [15:0]                      r_lfsr;
    logic                             w_lfsr_fb;

    logic [BITS_POS-1:0]              r_linha;
    logic [BITS_POS-1:0]              r_coluna;
    logic [BITS_POS-1:0]              r_mov_linha;
    logic [BITS_POS-1:0]              r_mov_coluna;
    logic [BITS_POS-1:0]              w_linha_nova;
    logic [BITS_POS-1:0]              w_coluna_lfsr;
    logic [BITS_POS-1:0]              w_coluna_nova;

    logic [W_TMR-1:0]                 r_timer;
    logic [W_JOG-1:0]                 r_jogador;
    logic [W_ROD-1:0]                 r_rodada;
    logic [W_ROD-1:0]                 w_rodada_inc;
    logic [N_JOGADORES*BITS_PONTOS-1:0] r_pontos;
    logic [BITS_PONTOS-1:0]           w_pontos_jog;

    logic                             r_salva;
    logic                             r_timeout;
    logic                             w_acerto;
    logic                             w_ultimo;
    logic                             w_aborta;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Candidate target; a repeat of the current target bumps the column so
    // two consecutive targets never coincide.
    assign w_linha_nova  = r_lfsr[BITS_POS-1:0];
    assign w_coluna_lfsr = r_lfsr[2*BITS_POS-1:BITS_POS];
    assign w_coluna_nova = (w_linha_nova == r_linha && w_coluna_lfsr == r_coluna)
                           ? w_coluna_lfsr + 1'b1 : w_coluna_lfsr;

    assign w_acerto      = (r_mov_linha == r_linha) && (r_mov_coluna == r_coluna);
    assign w_ultimo      = (r_jogador == ULTIMO_JOG);
    assign w_rodada_inc  = r_rodada + 1'b1;
    assign w_pontos_jog  = r_pontos[r_jogador*BITS_PONTOS +: BITS_PONTOS];

    // An abort discards whatever the current step would have committed.
    assign w_aborta      = terminar && (r_estado != INICIAL) && (r_estado != FIM);

    // NOTE: every next-state output gets its default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL: if (iniciar) w_prox = PREPARA;
            PREPARA: w_prox = GERA;
            GERA:    w_prox = ESPERA;
            ESPERA: begin
                // A move in the same cycle the window closes still counts.
                if (temJogada)           w_prox = AVALIA;
                else if (r_timer == '0)  w_prox = PROXIMO;
            end
            AVALIA:  w_prox = PROXIMO;
            PROXIMO: begin
                if (w_ultimo && w_rodada_inc == ROD_FINAL) w_prox = FIM;
                else                                       w_prox = GERA;
            end
            FIM:     if (iniciar) w_prox = PREPARA;
            default: w_prox = INICIAL;
        endcase
        if (w_aborta) w_prox = FIM;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) r_estado <= INICIAL;
        else        r_estado <= w_prox;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_lfsr       <= SEMENTE;
            r_linha      <= '0;
            r_coluna     <= '0;
            r_mov_linha  <= '0;
            r_mov_coluna <= '0;
            r_timer      <= '0;
            r_jogador    <= '0;
            r_rodada     <= '0;
            r_pontos     <= '0;
            r_salva      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
            r_salva   <= 1'b0;
            r_timeout <= 1'b0;
            if (!w_aborta) begin
                case (r_estado)
                    PREPARA: begin
                        r_pontos  <= '0;
                        r_rodada  <= '0;
                        r_jogador <= '0;
                        r_timer   <= '0;
                    end
                    GERA: begin
                        r_linha  <= w_linha_nova;
                        r_coluna <= w_coluna_nova;
                        r_timer  <= TMR_CARGA;
                        r_salva  <= 1'b1;
                    end
                    ESPERA: begin
                        if (temJogada) begin
                            r_mov_linha  <= jogadaLinha;
                            r_mov_coluna <= jogadaColuna;
                        end else if (r_timer == '0) begin
                            r_timeout <= 1'b1;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    AVALIA: begin
                        if (w_acerto && w_pontos_jog != PONTOS_MAX)
                            r_pontos[r_jogador*BITS_PONTOS +: BITS_PONTOS] <= w_pontos_jog + 1'b1;
                    end
                    PROXIMO: begin
                        if (w_ultimo) begin
                            r_jogador <= '0;
                            r_rodada  <= w_rodada_inc;
                        end else begin
                            r_jogador <= r_jogador + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign linhaGerada  = r_linha;
    assign colunaGerada = r_coluna;
    assign salvaNova    = r_salva;
    assign jogadorAtual = r_jogador;
    assign pontos       = r_pontos;
    assign rodada       = r_rodada;
    assign acertou      = (r_estado == AVALIA) && w_acerto;
    assign timeout      = r_timeout;
    assign fim          = (r_estado == FIM);
    assign db_estado    = {1'b0, r_estado};

endmodule

// File: doc/cl_rodada_param.md
CL_RODADA_PARAM -- requirements
Module: cl_rodada_param

Interface
REQ-001 Parameter N_JOGADORES, default 2, number of players taking turns, range 1..4.
REQ-002 Parameter BITS_POS, default 3, row and column width (board side 2^BITS_POS), with 2*BITS_POS <= 16.
REQ-003 Parameter N_RODADAS, default 8, number of rounds; one round is one move per player.
REQ-004 Parameter T_LIMITE, default 50000000, number of clock cycles allowed per move.
REQ-005 Parameter BITS_PONTOS, default 8, width of each player's score.
REQ-006 Ports, in the form name, direction, width, meaning:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- iniciar  in  1  start a game.
- terminar  in  1  abort the current game.
- jogadaLinha  in  BITS_POS  played row.
- jogadaColuna  in  BITS_POS  played column.
- temJogada  in  1  move-valid strobe.
- linhaGerada  out  BITS_POS  target row, registered.
- colunaGerada  out  BITS_POS  target column, registered.
- salvaNova  out  1  one-cycle pulse: a new target is valid.
- jogadorAtual  out  max(1,clog2(N_JOGADORES))  index of the player to move.
- pontos  out  N_JOGADORES*BITS_PONTOS  packed scores; player k occupies bits [k*BITS_PONTOS +: BITS_PONTOS].
- rodada  out  clog2(N_RODADAS+1)  number of completed rounds.
- acertou  out  1  one-cycle pulse: the move hit the target.
- timeout  out  1  one-cycle pulse: the move time expired.
- fim  out  1  level; high while in FIM.
- db_estado  out  4  state code.

Function
REQ-007 The FSM SHALL have these states and codes: INICIAL=0, PREPARA=1, GERA=2, ESPERA=3, AVALIA=4, PROXIMO=5, FIM=6.
REQ-008 INICIAL SHALL go to PREPARA when iniciar=1 and SHALL otherwise hold.
REQ-009 PREPARA SHALL, in one cycle, zero all scores, rodada, jogadorAtual and the move timer, then go to GERA.
REQ-010 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every cycle in every non-reset state.
REQ-011 On the edge leaving GERA, the target SHALL be loaded as row = lfsr[BITS_POS-1:0] and column = lfsr[2*BITS_POS-1:BITS_POS].
REQ-012 If the new target equals the previous target, the column SHALL be incremented modulo 2^BITS_POS instead, so no target repeats consecutively.
REQ-013 salvaNova SHALL be high exactly during the first ESPERA cycle after each GERA.
REQ-014 On entry to ESPERA, the timer SHALL load T_LIMITE-1 and then decrement once per ESPERA cycle.
REQ-015 In ESPERA with temJogada=1, the FSM SHALL latch jogadaLinha and jogadaColuna and go to AVALIA.
REQ-016 If temJogada=1 and the timer is 0 in the same cycle, the move SHALL win over the timeout.
REQ-017 In ESPERA with timer=0 and temJogada=0, the FSM SHALL pulse timeout for one cycle, go to PROXIMO and leave the score unchanged.
REQ-018 In AVALIA, when the latched move equals the target, acertou SHALL pulse for one cycle and score[jogadorAtual] SHALL increment, saturating at 2^BITS_PONTOS-1.
REQ-019 In AVALIA, a miss SHALL leave the score unchanged; AVALIA SHALL then go to PROXIMO.
REQ-020 In PROXIMO, jogadorAtual SHALL advance modulo N_JOGADORES, and rodada SHALL increment when jogadorAtual wraps to 0.
REQ-021 PROXIMO SHALL go to FIM if the incremented rodada equals N_RODADAS, and to GERA otherwise.
REQ-022 FIM SHALL hold the scores, rodada and target, drive fim=1, and go to PREPARA when iniciar=1.
REQ-023 In any state other than INICIAL and FIM, terminar=1 SHALL force FIM on the next edge, with priority over every other transition except reset.
REQ-024 A temJogada strobe outside ESPERA SHALL be ignored.
REQ-025 db_estado SHALL equal the current state code.

Reset
REQ-026 While reset=0 at a rising edge, the block SHALL enter INICIAL.
REQ-027 During reset, the LFSR SHALL load its seed and every output (targets, scores, rodada, jogadorAtual, pulses, fim, db_estado) SHALL be 0; this also applies when reset is asserted mid-game.

Verification
Common parameters for all scenarios: N_JOGADORES=2, BITS_POS=3, N_RODADAS=2, T_LIMITE=10.
REQ-028 Hit: iniciar, then on the salvaNova cycle drive the target with temJogada -> acertou=1 the next cycle, pontos[7:0]=1 afterwards, jogadorAtual=1.
REQ-029 Timeout: player 1 gives no move for 10 ESPERA cycles -> timeout=1 for one cycle, pontos[15:8]=0, jogadorAtual=0, rodada=1.
REQ-030 Full game: 4 moves (hit, miss, hit, hit) -> fim=1, rodada=2, pontos={8'd1,8'd2}, db_estado=6; a following iniciar clears everything.
REQ-031 Saturation: with BITS_PONTOS=2, N_RODADAS=5 and player 0 always hitting -> pontos[1:0]=3, not 1.
REQ-032 Abort and reset: terminar in ESPERA -> FIM the next cycle with scores kept; reset=0 in AVALIA -> all outputs 0 and db_estado=0.
REQ-033 Edge case: temJogada in the same cycle the timer reaches 0 -> the move is evaluated and no timeout pulse occurs; two consecutive targets always differ.
